// File: rtl/nios_system_hex_pkg.sv
// Shared types and constants for the HEX display arbiter: FSM states and
// the active-low 7-segment lookup (bit0=a .. bit6=g).
package nios_system_hex_pkg;
  localparam int DIGIT_W    = 7;
  localparam int NUM_DIGITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ENCODE,
    ST_WRITE,
    ST_HOLD
  } state_e;

  localparam logic [DIGIT_W-1:0] BLANK = 7'h7F;

  // Index 15 first: F, E, d, C, b, A, 9 .. 0
  localparam logic [15:0][DIGIT_W-1:0] SEG7 = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/nios_system_hex_seg7_enc.sv
// Combinational nibble to active-low 7-segment pattern.
module nios_system_hex_seg7_enc
  import nios_system_hex_pkg::*;
(
  input  logic [3:0]         nib,
  output logic [DIGIT_W-1:0] seg
);
  assign seg = SEG7[nib];
endmodule

// File: rtl/nios_system_hex_display_arbiter.sv
// Round-robin arbiter sharing the 4-digit HEX PIO between NUM_REQ requesters.
// Optional leading-zero blanking: define HEX_BLANK_LEADING_ZERO_EN.
module nios_system_hex_display_arbiter
  import nios_system_hex_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*16-1:0] req_value,
  output logic [NUM_REQ-1:0]    ack,
  output logic [2:0]            owner_id,
  output logic                  busy,
  output logic [1:0]            pio_address,
  output logic                  pio_chipselect,
  output logic                  pio_write_n,
  output logic [31:0]           pio_writedata
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_e         state_q, state_d;
  logic [2:0]     owner_q, owner_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [15:0]    val_q, val_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           grant_vld;
  logic [2:0]     grant_idx;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] enc, pat;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_enc
    nios_system_hex_seg7_enc u_enc (
      .nib (val_q[4*k +: 4]),
      .seg (enc[k])
    );
  end

`ifdef HEX_BLANK_LEADING_ZERO_EN
  logic [NUM_DIGITS-1:0] nz;
  // Digit k is blanked only when it and every digit above it are zero.
  always_comb begin
    nz  = '0;
    pat = enc;
    for (int k = 0; k < NUM_DIGITS; k++) nz[k] = |val_q[4*k +: 4];
    for (int k = 1; k < NUM_DIGITS; k++)
      if ((nz >> k) == '0) pat[k] = BLANK;
  end
`else
  assign pat = enc;
`endif

  // First request at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = 3'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    val_d   = val_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:   if (|req) state_d = ST_GRANT;
      ST_GRANT: begin
        if (grant_vld) begin
          owner_d = grant_idx;
          val_d   = req_value[16*grant_idx +: 16];
          state_d = ST_ENCODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENCODE: begin
        wdata_d = {4'b0, pat};
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        ptr_d   = (owner_q == 3'(NUM_REQ - 1)) ? 3'd0 : owner_q + 3'd1;
        cnt_d   = '0;
        state_d = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = ST_IDLE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      val_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      val_q   <= val_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from the state flop so reset drops them at once.
  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++)
      ack[i] = (state_q == ST_WRITE) && (owner_q == 3'(i));
  end

  assign pio_chipselect = (state_q == ST_WRITE);
  assign pio_write_n    = (state_q != ST_WRITE);
  assign pio_address    = 2'b00;
  assign pio_writedata  = wdata_q;
  assign owner_id       = owner_q;
  assign busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_nios_system_hex_display_arbiter.sv
// Directed bench: DUT A with HOLD_CYCLES=8, DUT B with HOLD_CYCLES=0.
module tb_nios_system_hex_display_arbiter;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_a = '0, req_b = '0;
  logic [63:0] val_a = '0, val_b = '0;
  logic [3:0]  ack_a, ack_b;
  logic [2:0]  owner_a, owner_b;
  logic        busy_a, busy_b, cs_a, cs_b, wn_a, wn_b;
  logic [1:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nios_system_hex_display_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(HOLD)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req_a), .req_value(val_a), .ack(ack_a),
    .owner_id(owner_a), .busy(busy_a), .pio_address(addr_a),
    .pio_chipselect(cs_a), .pio_write_n(wn_a), .pio_writedata(wdata_a));

  nios_system_hex_display_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req_b), .req_value(val_b), .ack(ack_b),
    .owner_id(owner_b), .busy(busy_b), .pio_address(addr_b),
    .pio_chipselect(cs_b), .pio_write_n(wn_b), .pio_writedata(wdata_b));

  task automatic wait_write(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!cs_a && cyc < 200);
    if (!cs_a) begin
      tests++; fails++;
      $display("FAIL write_timeout: no chipselect within %0d cycles", cyc);
    end
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (busy_a && cyc < 200);
    if (busy_a) begin
      tests++; fails++;
      $display("FAIL idle_timeout: busy still high after %0d cycles", cyc);
    end
  endtask

  task automatic do_write(input int idx, input logic [15:0] v, output logic [31:0] wd,
                          output logic [3:0] ak, output logic [2:0] own, output int lat);
    int d;
    @(negedge clk);
    req_a = 4'b0001 << idx;
    val_a[16*idx +: 16] = v;
    wait_write(lat);
    wd = wdata_a; ak = ack_a; own = owner_a;
    req_a = '0;
    wait_idle(d);
  endtask

  task automatic apply_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    tests++; if (ack_a !== 4'b0 || owner_a !== 3'd0 || busy_a !== 1'b0) begin fails++;
      $display("FAIL reset_ctrl: ack=%b owner=%0d busy=%b, want 0/0/0", ack_a, owner_a, busy_a); end
    tests++; if (cs_a !== 1'b0 || wn_a !== 1'b1 || addr_a !== 2'd0 || wdata_a !== 32'h0) begin fails++;
      $display("FAIL reset_pio: cs=%b wn=%b addr=%0d wd=%h, want 0/1/0/0", cs_a, wn_a, addr_a, wdata_a); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_single();
    int lat, hc;
    @(negedge clk);
    req_a = 4'b0100; val_a[47:32] = 16'h0000;
    wait_write(lat);
    tests++; if (lat !== 3) begin fails++; $display("FAIL single_latency: got %0d want 3", lat); end
`ifdef HEX_BLANK_LEADING_ZERO_EN
    tests++; if (wdata_a !== 32'h0FFFFFC0) begin fails++; $display("FAIL single_wdata: got %h want 0FFFFFC0", wdata_a); end
`else
    tests++; if (wdata_a !== 32'h08102040) begin fails++; $display("FAIL single_wdata: got %h want 08102040", wdata_a); end
`endif
    tests++; if (ack_a !== 4'b0100 || owner_a !== 3'd2 || wn_a !== 1'b0 || addr_a !== 2'd0) begin fails++;
      $display("FAIL single_strobe: ack=%b owner=%0d wn=%b addr=%0d, want 0100/2/0/0", ack_a, owner_a, wn_a, addr_a); end
    req_a = '0;
    @(negedge clk);
    tests++; if (cs_a !== 1'b0 || ack_a !== 4'b0 || busy_a !== 1'b1 || wdata_a[6:0] === 7'h0) begin fails++;
      $display("FAIL single_hold: cs=%b ack=%b busy=%b wd=%h, want 0/0/1/held", cs_a, ack_a, busy_a, wdata_a); end
    wait_idle(hc);
    tests++; if (hc !== HOLD) begin fails++; $display("FAIL single_hold_len: busy fell %0d cycles after write, want %0d", hc + 1, HOLD + 1); end
  endtask

  task automatic test_value_1238();
    logic [31:0] wd; logic [3:0] ak; logic [2:0] own; int lat, ncs;
    ncs = 0;
    fork
      do_write(0, 16'h1238, wd, ak, own, lat);
      repeat (20) begin @(negedge clk); if (cs_a) ncs++; end
    join
    tests++; if (wd !== 32'h0F291800) begin fails++; $display("FAIL value_1238: got %h want 0F291800", wd); end
    tests++; if (ncs !== 1 || ak !== 4'b0001 || own !== 3'd0) begin fails++;
      $display("FAIL value_1238_cs: cs_cycles=%0d ack=%b owner=%0d, want 1/0001/0", ncs, ak, own); end
  endtask

  task automatic test_blank();
    logic [31:0] wd; logic [3:0] ak; logic [2:0] own; int lat;
    logic [15:0] v [4]; logic [31:0] exp_wd [4];
    v = '{16'h0005, 16'h0000, 16'h0050, 16'h1005};
`ifdef HEX_BLANK_LEADING_ZERO_EN
    exp_wd = '{32'h0FFFFF92, 32'h0FFFFFC0, 32'h0FFFC940, 32'h0F302012};
`else
    exp_wd = '{32'h08102012, 32'h08102040, 32'h08100940, 32'h0F302012};
`endif
    for (int i = 0; i < 4; i++) begin
      do_write(1, v[i], wd, ak, own, lat);
      tests++; if (wd !== exp_wd[i]) begin fails++; $display("FAIL blank_%h: got %h want %h", v[i], wd, exp_wd[i]); end
    end
  endtask

  task automatic test_round_robin();
    int lat, d;
    logic [31:0] exp_wd [4];
    exp_wd = '{32'h01020408, 32'h0060C183, 32'h08D1A346, 32'h042850A1};
    apply_reset();
    val_a = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    req_a = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_write(lat);
      tests++; if (owner_a !== 3'(n % 4) || ack_a !== (4'b0001 << (n % 4)) || wdata_a !== exp_wd[n % 4]) begin fails++;
        $display("FAIL rr_grant%0d: owner=%0d ack=%b wd=%h, want %0d/%b/%h", n, owner_a, ack_a, wdata_a,
                 n % 4, 4'b0001 << (n % 4), exp_wd[n % 4]); end
      tests++; if (lat !== ((n == 0) ? 3 : HOLD + 4)) begin fails++;
        $display("FAIL rr_spacing%0d: got %0d want %0d", n, lat, (n == 0) ? 3 : HOLD + 4); end
    end
    req_a = '0;
    wait_idle(d);
  endtask

  task automatic test_hold0();
    int cyc;
    @(negedge clk);
    req_b = 4'b0010; val_b[31:16] = 16'h00A5;
    for (int n = 0; n < 4; n++) begin
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!cs_b && cyc < 50);
      tests++; if (cyc !== ((n == 0) ? 3 : 4) || ack_b !== 4'b0010 || owner_b !== 3'd1 || wn_b !== 1'b0 || addr_b !== 2'd0 || busy_b !== 1'b1) begin fails++;
        $display("FAIL hold0_write%0d: gap=%0d ack=%b owner=%0d wn=%b, want %0d/0010/1/0", n, cyc, ack_b, owner_b, wn_b, (n == 0) ? 3 : 4); end
    end
`ifdef HEX_BLANK_LEADING_ZERO_EN
    tests++; if (wdata_b !== 32'h0FFFC412) begin fails++; $display("FAIL hold0_wdata: got %h want 0FFFC412", wdata_b); end
`else
    tests++; if (wdata_b !== 32'h08100412) begin fails++; $display("FAIL hold0_wdata: got %h want 08100412", wdata_b); end
`endif
    req_b = '0;
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] wd; logic [3:0] ak; logic [2:0] own; int lat, d;
    do_write(2, 16'h2222, wd, ak, own, lat);
    @(negedge clk);
    req_a = 4'b1000; val_a[63:48] = 16'h3333;
    wait_write(lat);
    reset_n = 1'b0;
    #1;
    tests++; if (cs_a !== 1'b0 || wn_a !== 1'b1 || ack_a !== 4'b0 || owner_a !== 3'd0) begin fails++;
      $display("FAIL midreset_async: cs=%b wn=%b ack=%b owner=%0d, want 0/1/0000/0", cs_a, wn_a, ack_a, owner_a); end
    req_a = '0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    req_a = 4'b1001;
    wait_write(lat);
    tests++; if (owner_a !== 3'd0 || ack_a !== 4'b0001) begin fails++;
      $display("FAIL midreset_ptr: owner=%0d ack=%b, want 0/0001", owner_a, ack_a); end
    req_a = '0;
    wait_idle(d);
    do_write(3, 16'h3333, wd, ak, own, lat);
    tests++; if (own !== 3'd3 || ak !== 4'b1000) begin fails++;
      $display("FAIL midreset_req3: owner=%0d ack=%b, want 3/1000", own, ak); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_value_1238();
    test_blank();
    test_round_robin();
    test_hold0();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
